dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 194 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Wait-stated 16x16 data memory responder with a valid/ready request and response handshake.
// Optional per-word even parity with error injection when DMEM_PARITY_EN is defined.
module dmem_responder #(
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  input  logic        rsp_ready,
`ifdef DMEM_PARITY_EN
  input  logic        par_inj,
  output logic        par_err,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int         WAIT_M1   = (WAIT_CYC > 32'sd0) ? (WAIT_CYC - 32'sd1) : 32'sd0;
  localparam logic [2:0] WAIT_LOAD = WAIT_M1[2:0];

  function automatic logic even_par(input logic [15:0] d);
    return ^d;
  endfunction

  state_t      state_r;
  state_t      state_nx_s;
  logic [2:0]  cnt_r;
  logic [2:0]  cnt_nx_s;
  logic        accept_s;
  logic        commit_s;
  logic        we_r;
  logic [3:0]  addr_r;
  logic [15:0] wdata_r;
  logic        acc_we_s;
  logic [3:0]  acc_addr_s;
  logic [15:0] acc_wdata_s;
  logic [15:0] mem_r [16];
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [15:0] rsp_rdata_r;
  logic        busy_r;
`ifdef DMEM_PARITY_EN
  logic        par_r [16];
  logic        par_err_r;
`endif

  // Next-state, wait counter and commit decode
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    accept_s   = 1'b0;
    commit_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (WAIT_CYC == 32'sd0) begin
            state_nx_s = RESP;
            commit_s   = 1'b1;
            cnt_nx_s   = 3'd0;
          end else begin
            state_nx_s = WAIT;
            cnt_nx_s   = WAIT_LOAD;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 3'd0) begin
          state_nx_s = RESP;
          commit_s   = 1'b1;
        end else begin
          cnt_nx_s = cnt_r - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 3'd0;
      end
    endcase
  end

  // With zero wait states the commit happens on the accept edge, so use the live request
  always_comb begin
    acc_we_s    = we_r;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    if (state_r == IDLE) begin
      acc_we_s    = req_we;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
    end else begin
      acc_we_s    = we_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
    end
  end

  // State, counter and state-decoded output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      req_ready_r <= (state_nx_s == IDLE);
      busy_r      <= (state_nx_s != IDLE);
      rsp_valid_r <= (state_nx_s == RESP);
    end
  end

  // Request capture on acceptance; later req_* changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      addr_r  <= 4'd0;
      wdata_r <= 16'd0;
    end else if (accept_s) begin
      we_r    <= req_we;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
    end
  end

  // Storage array; a store only lands on the edge entering RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem_r[i] <= 16'd0;
`ifdef DMEM_PARITY_EN
        par_r[i] <= 1'b0;
`endif
      end
    end else if (commit_s && acc_we_s) begin
      mem_r[acc_addr_s] <= acc_wdata_s;
`ifdef DMEM_PARITY_EN
      par_r[acc_addr_s] <= even_par(acc_wdata_s) ^ par_inj;
`endif
    end
  end

  // Response data, held until the next commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata_r <= 16'd0;
    end else if (commit_s) begin
      rsp_rdata_r <= acc_we_s ? 16'd0 : mem_r[acc_addr_s];
    end
  end

`ifdef DMEM_PARITY_EN
  // Parity check result, live only for the duration of RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_r <= 1'b0;
    end else if (commit_s) begin
      par_err_r <= !acc_we_s && (even_par(mem_r[acc_addr_s]) != par_r[acc_addr_s]);
    end else if (state_nx_s != RESP) begin
      par_err_r <= 1'b0;
    end
  end

  assign par_err = par_err_r;
`endif

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: WAIT_CYC=1 main instance plus
// WAIT_CYC=0 and WAIT_CYC=7 instances for latency and issue-interval checks.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, rsp_ready;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata;
  logic        req_ready, rsp_valid, busy;
  logic [15:0] rsp_rdata;
`ifdef DMEM_PARITY_EN
  logic        par_inj, par_err, w0_perr, w7_perr;
`endif

  logic        l_valid, l_rsp_ready;
  logic        w0_req_ready, w0_rsp_valid, w0_busy;
  logic        w7_req_ready, w7_rsp_valid, w7_busy;
  logic [15:0] w0_rdata, w7_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ready(rsp_ready),
`ifdef DMEM_PARITY_EN
    .par_inj(par_inj), .par_err(par_err),
`endif
    .busy(busy)
  );

  dmem_responder #(.WAIT_CYC(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .req_valid(l_valid), .req_we(1'b0),
    .req_addr(4'd0), .req_wdata(16'd0), .req_ready(w0_req_ready),
    .rsp_valid(w0_rsp_valid), .rsp_rdata(w0_rdata), .rsp_ready(l_rsp_ready),
`ifdef DMEM_PARITY_EN
    .par_inj(1'b0), .par_err(w0_perr),
`endif
    .busy(w0_busy)
  );

  dmem_responder #(.WAIT_CYC(7)) u_w7 (
    .clk(clk), .rst_n(rst_n), .req_valid(l_valid), .req_we(1'b0),
    .req_addr(4'd0), .req_wdata(16'd0), .req_ready(w7_req_ready),
    .rsp_valid(w7_rsp_valid), .rsp_rdata(w7_rdata), .rsp_ready(l_rsp_ready),
`ifdef DMEM_PARITY_EN
    .par_inj(1'b0), .par_err(w7_perr),
`endif
    .busy(w7_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; ends at a negedge with the DUT back in IDLE.
  task automatic access(input logic we, input logic [3:0] a, input logic [15:0] d,
                        input string tag, output logic [15:0] rd, output logic pe);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~d;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_rdy0"}, req_ready, 0);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 2);
    rd = rsp_rdata;
`ifdef DMEM_PARITY_EN
    pe = par_err;
`else
    pe = 1'b0;
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rdy1"}, req_ready, 1);
  endtask

  initial begin
    logic [15:0] rd;
    logic        pe;
    int          n, lat0, lat7, cnt;
    logic        rdy_bad;

    req_valid = 1'b0; req_we = 1'b0; req_addr = 4'd0; req_wdata = 16'd0; rsp_ready = 1'b0;
    l_valid = 1'b0; l_rsp_ready = 1'b0;
`ifdef DMEM_PARITY_EN
    par_inj = 1'b0;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    access(1'b0, 4'd5, 16'h0000, "ld5", rd, pe);
    chk("ld5_data", rd, 16'h0000);
    access(1'b1, 4'd3, 16'hBEEF, "st3", rd, pe);
    chk("st3_data", rd, 16'h0000);
    access(1'b0, 4'd3, 16'h0000, "ld3", rd, pe);
    chk("ld3_data", rd, 16'hBEEF);
    access(1'b0, 4'd4, 16'h0000, "ld4", rd, pe);
    chk("ld4_data", rd, 16'h0000);
    access(1'b1, 4'd15, 16'hA5A5, "st15", rd, pe);
    access(1'b1, 4'd0, 16'h5A5A, "st0", rd, pe);
    access(1'b0, 4'd15, 16'h0000, "ld15", rd, pe);
    chk("ld15_data", rd, 16'hA5A5);
    access(1'b0, 4'd0, 16'h0000, "ld0", rd, pe);
    chk("ld0_data", rd, 16'h5A5A);

    // Backpressure: response held, a new request waits for IDLE
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_lat", n, 2);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 16'hBEEF);
      chk("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_noacc_busy", busy, 0);
    chk("bp_noacc_rdy", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_acc_busy", busy, 1);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_st_lat", n, 2);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    access(1'b0, 4'd3, 16'h0000, "ld3b", rd, pe);
    chk("ld3b_data", rd, 16'hDEAD);

    // Reset during WAIT aborts the store and clears memory
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd7; req_wdata = 16'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 4'd7, 16'h0000, "ld7", rd, pe);
    chk("ld7_data", rd, 16'h0000);
    access(1'b0, 4'd3, 16'h0000, "ld3c", rd, pe);
    chk("ld3c_data", rd, 16'h0000);

`ifdef DMEM_PARITY_EN
    par_inj = 1'b1;
    access(1'b1, 4'd2, 16'h0001, "pst_bad", rd, pe);
    par_inj = 1'b0;
    chk("pst_bad_perr", pe, 0);
    access(1'b0, 4'd2, 16'h0000, "pld_bad", rd, pe);
    chk("pld_bad_perr", pe, 1);
    chk("pld_bad_data", rd, 16'h0001);
    chk("perr_clear", par_err, 0);
    access(1'b1, 4'd2, 16'h0001, "pst_ok", rd, pe);
    access(1'b0, 4'd2, 16'h0000, "pld_ok", rd, pe);
    chk("pld_ok_perr", pe, 0);
`endif

    // WAIT_CYC=0 versus WAIT_CYC=7 latency, ready low throughout
    l_valid = 1'b1;
    @(negedge clk);
    l_valid = 1'b0;
    lat0 = 0; lat7 = 0; rdy_bad = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      if (lat0 == 0 && w0_rsp_valid) lat0 = e;
      if (lat7 == 0 && w7_rsp_valid) lat7 = e;
      if (w0_req_ready || w7_req_ready) rdy_bad = 1'b1;
      @(negedge clk);
    end
    chk("w0_lat", lat0, 1);
    chk("w7_lat", lat7, 8);
    chk("lat_rdy_low", rdy_bad, 0);
    chk("w7_busy", w7_busy, 1);
    l_rsp_ready = 1'b1;
    @(negedge clk);
    chk("w0_idle", w0_req_ready, 1);
    chk("w7_idle", w7_req_ready, 1);

    // Back-to-back issue with zero wait states: one response every 2 cycles
    l_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (w0_rsp_valid) cnt++;
    end
    l_valid = 1'b0;
    chk("w0_interval", cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
